// File: rtl/mult_accumulator.sv
// Batch accumulator for unsigned 2x2-bit multiplier products: sums N_PRODUCTS
// accepted products into an ACC_W-bit total and hands it downstream with valid/ready.
module mult_accumulator #(
  parameter int N_PRODUCTS = 4,
  parameter int ACC_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       product,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = $clog2(N_PRODUCTS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [ACC_W-1:0]   acc_r;
  logic [CNT_W-1:0]   count_r;
  logic               ovf_r;
  logic               in_ready_r;
  logic               sum_valid_r;
  logic               busy_r;

  logic [ACC_W:0]     add_s;
  logic               last_s;

  // Carry-extended sum of the running total and the incoming product.
  always_comb begin
    add_s  = {1'b0, acc_r} + {{(ACC_W - 3){1'b0}}, product};
    last_s = (count_r == CNT_W'(N_PRODUCTS - 1));
  end

  // Batch control FSM; the handshake flags are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      count_r     <= '0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      sum_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= ACCUM;
            acc_r      <= '0;
            count_r    <= '0;
            ovf_r      <= 1'b0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_r   <= add_s[ACC_W-1:0];
            ovf_r   <= ovf_r | add_s[ACC_W];
            count_r <= count_r + CNT_W'(1);
            if (last_s) begin
              // Final product: result becomes visible on the very next cycle.
              state_r     <= DONE;
              in_ready_r  <= 1'b0;
              sum_valid_r <= 1'b1;
            end
          end
        end
        DONE: begin
          if (sum_ready) begin
            state_r     <= IDLE;
            sum_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          sum_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign sum       = acc_r;
  assign sum_valid = sum_valid_r;
  assign overflow  = ovf_r;
  assign busy      = busy_r;

endmodule

// File: doc/mult_accumulator.md
MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

Interface
REQ-001 Parameter N_PRODUCTS, default 4, SHALL set the number of products summed per batch (legal range 1..16).
REQ-002 Parameter ACC_W, default 8, SHALL set the accumulator and sum width in bits (legal range 4..16).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be a synchronous, active-low reset.
REQ-005 Port start, input, 1, SHALL request a new batch.
REQ-006 Port product, input, 4, SHALL carry the unsigned 2x2-bit multiplier result f3..f0 from the upstream multiplier stage.
REQ-007 Port in_valid, input, 1, SHALL qualify product.
REQ-008 Port in_ready, output, 1, SHALL indicate that a product can be accepted.
REQ-009 Port sum, output, ACC_W, SHALL present the batch total.
REQ-010 Port sum_valid, output, 1, SHALL qualify sum.
REQ-011 Port sum_ready, input, 1, SHALL indicate that downstream accepts sum.
REQ-012 Port overflow, output, 1, SHALL flag that the batch total exceeded 2^ACC_W-1.
REQ-013 Port busy, output, 1, SHALL be high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-015 In IDLE with start=1, the block SHALL clear acc, count and overflow and enter ACCUM on the next edge.
REQ-016 In IDLE, start=0 SHALL leave all state unchanged.
REQ-017 start SHALL be ignored in ACCUM and DONE.
REQ-018 in_ready SHALL be 1 only in ACCUM (Moore output, no combinational path from in_valid).
REQ-019 A product SHALL be accepted on any edge where in_valid=1 and in_ready=1.
REQ-020 On acceptance, acc SHALL update to (acc + zero-extended product) mod 2^ACC_W, and count SHALL increment by 1.
REQ-021 On acceptance, overflow SHALL be set if that addition carries out of bit ACC_W-1; overflow SHALL be sticky until the next start or reset.
REQ-022 The acceptance that brings count to N_PRODUCTS SHALL move the FSM to DONE on the same edge.
REQ-023 The sum from REQ-022 SHALL include that final product, with latency 1 cycle from the final accepted product to sum_valid=1.
REQ-024 Cycles in ACCUM with in_valid=0 SHALL change no state; there is no timeout.
REQ-025 In DONE, sum_valid SHALL be 1, and sum and overflow SHALL be held stable until the handshake.
REQ-026 In DONE, sum_valid=1 and sum_ready=1 on an edge SHALL return the FSM to IDLE.
REQ-027 sum_valid SHALL deassert in the cycle after that handshake.
REQ-028 sum SHALL continue to show the last total in IDLE until the next start clears it.
REQ-029 If sum_ready is held high before DONE is entered, the result SHALL still be presented for one full cycle (sum_valid=1 for exactly one cycle).
REQ-030 With N_PRODUCTS=1, a single accepted product SHALL go directly ACCUM -> DONE.
REQ-031 count SHALL be ceil(log2(N_PRODUCTS+1)) bits wide and SHALL never wrap within a batch.

Reset
REQ-032 rst_n=0 at an edge SHALL, from any state including mid-batch, force the FSM to IDLE.
REQ-033 The same reset SHALL set acc=0, count=0, sum=0, overflow=0, sum_valid=0, in_ready=0 and busy=0.
REQ-034 Reset SHALL take priority over start, in_valid and sum_ready on the same edge.
REQ-035 No partial batch SHALL survive reset.
REQ-036 Outputs SHALL hold their reset values while rst_n=0.

Verification
REQ-037 Basic batch: defaults; start; products 9,6,4,1 on consecutive cycles with in_valid=1 -> sum_valid=1 one cycle after the 4th, sum=20, overflow=0.
REQ-038 Gaps and backpressure: products 3,(gap),2,(gap,gap),9,4 with sum_ready=0 for 5 cycles after DONE -> sum=18 held stable with sum_valid=1 for all 5 cycles; IDLE one cycle after sum_ready=1.
REQ-039 Overflow: ACC_W=5, N_PRODUCTS=4; products 9,9,9,9 -> sum=4 (36 mod 32), overflow=1; next start -> overflow=0.
REQ-040 Mid-batch reset: defaults; accept 9,9; rst_n=0 for one cycle -> busy=0, sum=0, in_ready=0.
REQ-041 Re-batch after mid-batch reset: following the reset of REQ-040, start plus 1,1,1,1 -> sum=4.
REQ-042 Ignored inputs: start pulses in ACCUM and DONE cause no restart; in_valid=1 in IDLE/DONE is not accepted (count unchanged).
REQ-043 Exhaustive product sweep: N_PRODUCTS=1; start and each legal product in {0,1,2,3,4,6,9} -> sum equals that product, one cycle latency.
